// File: rtl/racod_query_sched.sv
// Round-robin scheduler sharing one racod_top collision core among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining RACOD_SCHED_TIMEOUT_EN.
module racod_query_sched #(
  parameter int NUM_REQ     = 4,
  parameter int CFG_W       = 192,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CFG_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic                     resp_collision,
  output logic                     resp_timeout,
  output logic [CFG_W-1:0]         cfg_data,
  output logic                     cfg_valid,
  input  logic                     core_done,
  input  logic                     core_collision,
  output logic                     busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("racod_query_sched: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("racod_query_sched: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        ptr, ptr_nxt, gnt, gnt_nxt;
  logic [IW-1:0]        arb_idx, arb_cand;
  logic                 arb_hit, take;
  logic [CFG_W-1:0]     arb_data, cfg_data_nxt;
  logic [NUM_REQ-1:0]   ready_nxt, resp_valid_nxt;
  logic                 cfg_valid_nxt, coll_nxt, to_nxt, busy_nxt;

`ifdef RACOD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
`endif

  // Arbitration: first asserted request searching upward from ptr+1, wrapping.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!arb_hit && req_valid[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
    arb_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == arb_idx) arb_data = req_data[i*CFG_W +: CFG_W];
    end
  end

  // Next-state and registered-output values; a grant is registered so req_ready
  // is seen in an IDLE cycle, letting RESP overlap the next arbitration.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    gnt_nxt        = gnt;
    cfg_data_nxt   = cfg_data;
    ready_nxt      = '0;
    resp_valid_nxt = '0;
    cfg_valid_nxt  = 1'b0;
    coll_nxt       = 1'b0;
    to_nxt         = 1'b0;
    take           = 1'b0;
`ifdef RACOD_SCHED_TIMEOUT_EN
    wait_cnt_nxt   = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req_ready) begin
          state_nxt     = ISSUE;
          cfg_valid_nxt = 1'b1;
        end else begin
          take = arb_hit;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
`ifdef RACOD_SCHED_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      WAIT: begin
        if (core_done) begin
          state_nxt      = RESP;
          resp_valid_nxt = ONE << gnt;
          coll_nxt       = core_collision;
        end
`ifdef RACOD_SCHED_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) begin
          state_nxt      = RESP;
          resp_valid_nxt = ONE << gnt;
          coll_nxt       = 1'b1;
          to_nxt         = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
`endif
      end
      RESP: begin
        state_nxt = IDLE;
        take      = arb_hit;
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      ready_nxt    = ONE << arb_idx;
      cfg_data_nxt = arb_data;
      gnt_nxt      = arb_idx;
      ptr_nxt      = arb_idx;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ptr            <= IW'(NUM_REQ - 1);
      gnt            <= '0;
      cfg_data       <= '0;
      req_ready      <= '0;
      resp_valid     <= '0;
      cfg_valid      <= 1'b0;
      resp_collision <= 1'b0;
      resp_timeout   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      gnt            <= gnt_nxt;
      cfg_data       <= cfg_data_nxt;
      req_ready      <= ready_nxt;
      resp_valid     <= resp_valid_nxt;
      cfg_valid      <= cfg_valid_nxt;
      resp_collision <= coll_nxt;
      resp_timeout   <= to_nxt;
      busy           <= busy_nxt;
    end
  end

`ifdef RACOD_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= '0;
    else      wait_cnt <= wait_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_racod_query_sched.sv
// Directed bench for racod_query_sched; covers the timeout path when RACOD_SCHED_TIMEOUT_EN is defined.
module tb_racod_query_sched;

  localparam int NR = 4;
  localparam int CW = 192;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*CW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready, resp_valid;
  logic            resp_collision, resp_timeout, cfg_valid, busy;
  logic [CW-1:0]   cfg_data;
  logic            core_done = 1'b0;
  logic            core_collision = 1'b0;
  logic [11:0]     obs;

  int n_cmp = 0;
  int n_bad = 0;

  racod_query_sched #(.NUM_REQ(NR), .CFG_W(CW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_collision(resp_collision),
    .resp_timeout(resp_timeout), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .core_done(core_done), .core_collision(core_collision), .busy(busy)
  );

  always #5 clk = ~clk;

  // {req_ready, cfg_valid, resp_valid, resp_collision, resp_timeout, busy}
  assign obs = {req_ready, cfg_valid, resp_valid, resp_collision, resp_timeout, busy};

  function automatic logic [CW-1:0] cfg_word(input int base);
    return {32'(base + 5), 32'(base + 4), 32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; core_done = 1'b0; core_collision = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL reset_async obs=%b exp=%b", obs, 12'd0); end
    n_cmp++;
    if (cfg_data !== '0) begin n_bad++; $display("FAIL reset_cfg_data got=%h exp=0", cfg_data); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL reset_held obs=%b exp=%b", obs, 12'd0); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [11:0] exp;
    reset_dut();
    core_collision = 1'b1;
    req_valid = 4'b0001;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      case (c)
        0:       exp = {4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        1:       exp = {4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
        2, 3, 4: exp = {4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        5:       exp = {4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1};
        default: exp = '0;
      endcase
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL single_c%0d obs=%b exp=%b", c, obs, exp); end
      if (c >= 1 && c <= 5) begin
        n_cmp++;
        if (cfg_data !== cfg_word(1))
          begin n_bad++; $display("FAIL single_cfg_c%0d got=%h exp=%h", c, cfg_data, cfg_word(1)); end
      end
      if (c == 0) req_valid = '0;
      core_done = (c == 4);
    end
    core_done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [11:0] exp;
    logic [3:0]  oh;
    int g, ph;
    reset_dut();
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      g  = (c / 4) % 4;
      ph = c % 4;
      oh = 4'b0001 << g;
      exp = {(ph == 0) ? oh : 4'b0000, ph == 1, (ph == 3) ? oh : 4'b0000,
             (ph == 3) && (g % 2 == 1), 1'b0, ph != 0};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL rr_c%0d obs=%b exp=%b", c, obs, exp); end
      if (ph == 1) begin
        n_cmp++;
        if (cfg_data !== cfg_word(1 + 16 * g))
          begin n_bad++; $display("FAIL rr_cfg_c%0d got=%h exp=%h", c, cfg_data, cfg_word(1 + 16 * g)); end
      end
      core_done      = (ph == 2);
      core_collision = (g % 2 == 1);
      if (c == 19) req_valid = '0;
    end
    core_done = 1'b0;
  endtask

  task automatic test_late_joiner();
    logic [11:0] exp;
    logic [3:0]  oh;
    int g, ph;
    reset_dut();
    core_collision = 1'b0;
    req_valid = 4'b0101;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      g  = (c < 4) ? 0 : (c < 8) ? 1 : 2;
      ph = c % 4;
      oh = 4'b0001 << g;
      if (c == 12) exp = '0;
      else exp = {(ph == 0) ? oh : 4'b0000, ph == 1, (ph == 3) ? oh : 4'b0000, 1'b0, 1'b0, ph != 0};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL late_c%0d obs=%b exp=%b", c, obs, exp); end
      if (ph == 0) req_valid[g] = 1'b0;
      if (c == 2) req_valid[1] = 1'b1;
      core_done = (ph == 2) && (c < 12);
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [11:0] exp;
    reset_dut();
    core_collision = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0; core_done = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL rstwait_async obs=%b exp=%b", obs, 12'd0); end
    n_cmp++;
    if (cfg_data !== '0) begin n_bad++; $display("FAIL rstwait_cfg got=%h exp=0", cfg_data); end
    @(negedge clk);
    core_done = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 12'd0) begin n_bad++; $display("FAIL rstwait_quiet_c%0d obs=%b exp=%b", c, obs, 12'd0); end
    end
    core_collision = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      case (c)
        0:       exp = {4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        1:       exp = {4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
        2:       exp = {4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        3:       exp = {4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1};
        default: exp = '0;
      endcase
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL rstwait_fresh_c%0d obs=%b exp=%b", c, obs, exp); end
      if (c == 0) req_valid = '0;
      core_done = (c == 2);
    end
    core_done = 1'b0;
  endtask

  task automatic test_spurious();
    logic [11:0] exp;
    reset_dut();
    core_collision = 1'b1;
    core_done = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'd0) begin n_bad++; $display("FAIL spur_idle obs=%b exp=%b", obs, 12'd0); end
    req_valid = 4'b0001;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      case (c)
        0:       exp = {4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        1:       exp = {4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
        2, 3, 4: exp = {4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        5:       exp = {4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
        default: exp = '0;
      endcase
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL spur_c%0d obs=%b exp=%b", c, obs, exp); end
      if (c == 0) req_valid = '0;
      core_done      = (c == 0) || (c == 1) || (c == 4);
      core_collision = (c != 4);
    end
    core_done = 1'b0;
  endtask

  // Pass 0: core never answers. Pass 1: core answers on the last WAIT cycle.
  task automatic test_timeout();
    logic [11:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      reset_dut();
      core_collision = 1'b0;
      req_valid = 4'b0001;
      for (int c = 0; c <= 11; c++) begin
        @(negedge clk);
        if (c == 0)      exp = {4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        else if (c == 1) exp = {4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
        else if (c <= 9) exp = {4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        else if (pass == 1)
          exp = (c == 10) ? {4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1} : 12'd0;
        else begin
`ifdef RACOD_SCHED_TIMEOUT_EN
          exp = (c == 10) ? {4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1} : 12'd0;
`else
          exp = {4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
`endif
        end
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL timeout_p%0d_c%0d obs=%b exp=%b", pass, c, obs, exp); end
        if (c == 0) req_valid = '0;
        core_done = (pass == 1) && (c == 9);
      end
      core_done = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) req_data[i*CW +: CW] = cfg_word(1 + 16 * i);
    test_reset();
    test_single();
    test_round_robin();
    test_late_joiner();
    test_reset_mid_wait();
    test_spurious();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
